// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op encoding and state type for muldiv_hilo.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Magnitude of v when treated as signed, raw v otherwise.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or
// restoring divide (divide path present only with MULDIV_DIV_EN).
module muldiv_step
    import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic                is_div,
`endif
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opnd_i,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {partial remainder, dividend/quotient shift reg}.
    always_comb begin
        sum   = {1'b0, acc_i[2*XLEN-1:XLEN]}
              + (acc_i[0] ? {1'b0, opnd_i} : '0);
        acc_o = {sum, acc_i[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        sh   = acc_i[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, opnd_i};
        if (is_div) begin
            if (!diff[XLEN])
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            else
                acc_o = {sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end
`endif
    end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit owning HI/LO.
// Define MULDIV_DIV_EN to include div/divu; otherwise they are ignored.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d, step_acc, prod_neg;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            neg_lo_q, neg_lo_d;
    logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;
    logic            sgn;
`ifdef MULDIV_DIV_EN
    logic            is_div_q, is_div_d;
    logic            neg_hi_q, neg_hi_d;
    logic            div0_q, div0_d;
`endif

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .is_div (is_div_q),
`endif
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Request decode, iteration control and sign-corrected commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sgn      = ~op[0];
        prod_neg = -acc_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {{W{1'b0}}, mag(b, sgn)};
                            opnd_d   = mag(a, sgn);
                            neg_lo_d = sgn & (a[W-1] ^ b[W-1]);
                            cnt_d    = '0;
                            state_d  = S_CALC;
`ifdef MULDIV_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            if (b == '0) begin
                                done_d = 1'b1;
                            end else begin
                                acc_d    = {{W{1'b0}}, mag(a, sgn)};
                                opnd_d   = mag(b, sgn);
                                neg_lo_d = sgn & (a[W-1] ^ b[W-1]);
                                neg_hi_d = sgn & a[W-1];
                                is_div_d = 1'b1;
                                cnt_d    = '0;
                                state_d  = S_CALC;
                            end
                        end
`endif
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = neg_lo_q ? prod_neg[2*W-1:W] : acc_q[2*W-1:W];
                lo_d    = neg_lo_q ? prod_neg[W-1:0] : acc_q[W-1:0];
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
                end
`endif
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULDIV_DIV_EN
    // div0 is re-evaluated on every accepted request and held otherwise.
    always_comb begin
        div0_d = div0_q;
        if (state_q == S_IDLE && start && op <= OP_MTLO)
            div0_d = (op == OP_DIV || op == OP_DIVU) && (b == '0);
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors for muldiv_hilo.
// Covers the MULDIV_DIV_EN build or the multiply-only build.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int cyc;
    logic seen;

    muldiv_hilo dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int c0,
                             output int n, output logic s);
        n = c0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        s = done;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_div0", 32'(div0), 32'h0);

        // -3 * 7
        issue(3'b000, 32'hFFFFFFFD, 32'd7);
        chk("mult_busy", 32'(busy), 32'h1);
        chk("mult_hi_stable", hi, 32'h0);
        wait_done(60, 0, cyc, seen);
        chk("mult_lat", 32'(cyc), 32'd33);
        chk("mult_busy_off", 32'(busy), 32'h0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        // back-to-back multu issued in the done cycle
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("b2b_done_low", 32'(done), 32'h0);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done(60, 0, cyc, seen);
        chk("multu_lat", 32'(cyc), 32'd33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(60, 0, cyc, seen);
        chk("mults_hi", hi, 32'h0);
        chk("mults_lo", lo, 32'h1);

        // mthi / mtlo
        @(negedge clk);
        issue(3'b100, 32'h12345678, 32'h0);
        chk("mthi_done", 32'(done), 32'h1);
        chk("mthi_busy", 32'(busy), 32'h0);
        chk("mthi_hi", hi, 32'h12345678);
        issue(3'b101, 32'h9ABCDEF0, 32'h0);
        chk("mtlo_done", 32'(done), 32'h1);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        @(negedge clk);
        chk("mtlo_pulse", 32'(done), 32'h0);

`ifdef MULDIV_DIV_EN
        issue(3'b011, 32'd100, 32'd0);
        chk("dz_done", 32'(done), 32'h1);
        chk("dz_div0", 32'(div0), 32'h1);
        chk("dz_busy", 32'(busy), 32'h0);
        chk("dz_hi", hi, 32'h12345678);
        chk("dz_lo", lo, 32'h9ABCDEF0);
        @(negedge clk);
        issue(3'b000, 32'd2, 32'd3);
        chk("dz_clr", 32'(div0), 32'h0);
        wait_done(60, 0, cyc, seen);
        chk("dz_mult_lo", lo, 32'd6);

        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(60, 0, cyc, seen);
        chk("div_lat", 32'(cyc), 32'd33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue(3'b011, 32'd100, 32'd7);
        wait_done(60, 0, cyc, seen);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(60, 0, cyc, seen);
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h0);
        chk("divmin_div0", 32'(div0), 32'h0);
`else
        issue(3'b010, 32'd10, 32'd2);
        wait_done(40, 0, cyc, seen);
        chk("nodiv_done", 32'(seen), 32'h0);
        chk("nodiv_busy", 32'(busy), 32'h0);
        chk("nodiv_hi", hi, 32'h12345678);
        chk("nodiv_lo", lo, 32'h9ABCDEF0);
        chk("nodiv_div0", 32'(div0), 32'h0);
        issue(3'b100, 32'hCAFEF00D, 32'h0);
        chk("nodiv_mthi_done", 32'(done), 32'h1);
        chk("nodiv_mthi", hi, 32'hCAFEF00D);
`endif

        // reserved op: nothing happens
        @(negedge clk);
        begin
            logic [31:0] h0, l0;
            h0 = hi; l0 = lo;
            issue(3'b110, 32'h1111, 32'h2222);
            wait_done(5, 0, cyc, seen);
            chk("rsv_done", 32'(seen), 32'h0);
            chk("rsv_busy", 32'(busy), 32'h0);
            chk("rsv_hi", hi, h0);
            chk("rsv_lo", lo, l0);
        end

        // start re-pulsed mid-calculation is ignored
        issue(3'b001, 32'h1234, 32'h10);
        cyc = 0;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        op = 3'b010; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        wait_done(60, cyc, cyc, seen);
        chk("rep_lat", 32'(cyc), 32'd33);
        chk("rep_hi", hi, 32'h0);
        chk("rep_lo", lo, 32'h00012340);

        // reset mid-calculation
        issue(3'b000, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_hi", hi, 32'h0);
        chk("mrst_lo", lo, 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_done", 32'(done), 32'h0);
        issue(3'b000, 32'd3, 32'd4);
        chk("mrst_accept", 32'(busy), 32'h1);
        wait_done(60, 0, cyc, seen);
        chk("mrst_lat", 32'(cyc), 32'd33);
        chk("mrst_lo2", lo, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
